// File: rtl/snake_body.sv
// Circular-buffer store of snake segments, streamed head-first one segment per clock.
// Optional self-collision detector enabled by defining SNAKE_SELF_COLLISION_EN.
module snake_body #(
   parameter int         MAX_LEN = 64,
   parameter logic [4:0] START_X = 5'd4,
   parameter logic [3:0] START_Y = 4'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_valid,
   input  logic [4:0] move_x,
   input  logic [3:0] move_y,
   input  logic       grow,
   output logic       move_ready,
   output logic [4:0] snake_x,
   output logic [3:0] snake_y,
   output logic       snake_first,
   output logic       snake_last,
   output logic       snake_valid,
   output logic [4:0] snake_head_x,
   output logic [3:0] snake_head_y,
   output logic       full,
   output logic       self_hit
);

   localparam int AW = $clog2(MAX_LEN);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
   localparam logic [AW:0]   LEN_MAX = (AW+1)'(MAX_LEN);

   logic [8:0]    mem [MAX_LEN];
   logic [8:0]    rd_data_q;

   logic [AW-1:0] head_ptr_q, head_ptr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] rd_q, rd_d;
   logic          full_q, full_d;
   logic          valid_q, first_q, last_q;
   logic [4:0]    head_x_q;
   logic [3:0]    head_y_q;

   logic          at_boundary;
   logic          accept;
   logic [AW-1:0] rd_addr;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [8:0]    wr_data;

   assign at_boundary = ({1'b0, rd_q} == (len_q - LEN_ONE));
   assign move_ready  = ~rst & at_boundary;
   assign accept      = move_ready & move_valid;
   assign rd_addr     = head_ptr_q - rd_q;

   // Reset seeds the head slot through the normal write port so the array stays a plain RAM.
   assign wr_en   = rst | accept;
   assign wr_addr = rst ? '0 : head_ptr_q + PTR_ONE;
   assign wr_data = rst ? {START_X, START_Y} : {move_x, move_y};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= mem[rd_addr];
   end

   always_comb begin
      head_ptr_d = head_ptr_q;
      len_d      = len_q;
      full_d     = full_q;
      rd_d       = at_boundary ? '0 : rd_q + PTR_ONE;
      if (accept) begin
         head_ptr_d = head_ptr_q + PTR_ONE;
         if (grow) begin
            if (len_q == LEN_MAX) begin
               full_d = 1'b1;
            end else begin
               len_d = len_q + LEN_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr_q <= '0;
         len_q      <= LEN_ONE;
         rd_q       <= '0;
         full_q     <= 1'b0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         head_x_q   <= START_X;
         head_y_q   <= START_Y;
      end else begin
         head_ptr_q <= head_ptr_d;
         len_q      <= len_d;
         rd_q       <= rd_d;
         full_q     <= full_d;
         valid_q    <= 1'b1;
         first_q    <= (rd_q == '0);
         last_q     <= at_boundary;
         if (accept) begin
            head_x_q <= move_x;
            head_y_q <= move_y;
         end
      end
   end

   assign snake_x      = valid_q ? rd_data_q[8:4] : 5'd0;
   assign snake_y      = valid_q ? rd_data_q[3:0] : 4'd0;
   assign snake_valid  = valid_q;
   assign snake_first  = first_q;
   assign snake_last   = last_q;
   assign snake_head_x = head_x_q;
   assign snake_head_y = head_y_q;
   assign full         = full_q;

`ifdef SNAKE_SELF_COLLISION_EN
   // Segment 0 is latched as it streams so every later segment of the same pass is
   // compared against that pass's own head; the verdict folds in on the pass's last segment.
   logic [8:0] seg0_q;
   logic       flag_q;
   logic       hit_q;
   logic       seg_match;

   assign seg_match = valid_q & ~first_q & (rd_data_q == seg0_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         seg0_q <= '0;
         flag_q <= 1'b0;
         hit_q  <= 1'b0;
      end else begin
         if (valid_q & first_q) begin
            seg0_q <= rd_data_q;
         end
         if (valid_q & last_q) begin
            hit_q  <= hit_q | flag_q | seg_match;
            flag_q <= 1'b0;
         end else begin
            flag_q <= flag_q | seg_match;
         end
      end
   end

   assign self_hit = hit_q;
`else
   assign self_hit = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: directed scenarios plus randomized moves
// checked against a queue-based model of the snake body.
module tb_snake_body;

   localparam int TB_MAX = 8;
`ifdef SNAKE_SELF_COLLISION_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       move_valid;
   logic [4:0] move_x;
   logic [3:0] move_y;
   logic       grow;
   logic       move_ready;
   logic [4:0] snake_x;
   logic [3:0] snake_y;
   logic       snake_first, snake_last, snake_valid;
   logic [4:0] snake_head_x;
   logic [3:0] snake_head_y;
   logic       full, self_hit;

   int total = 0;
   int bad   = 0;

   logic [8:0] model_q[$];
   bit         model_full;
   bit         hit_sticky;

   always #5 clk = ~clk;

   snake_body #(.MAX_LEN(TB_MAX), .START_X(5'd4), .START_Y(4'd8)) dut (
      .clk(clk), .rst(rst), .move_valid(move_valid), .move_x(move_x), .move_y(move_y),
      .grow(grow), .move_ready(move_ready), .snake_x(snake_x), .snake_y(snake_y),
      .snake_first(snake_first), .snake_last(snake_last), .snake_valid(snake_valid),
      .snake_head_x(snake_head_x), .snake_head_y(snake_head_y), .full(full),
      .self_hit(self_hit)
   );

   function automatic bit snap_hit();
      for (int i = 1; i < model_q.size(); i++)
         if (model_q[i] == model_q[0]) return 1'b1;
      return 1'b0;
   endfunction

   // Called at a negedge; holds rst over one posedge, checks reset values, releases.
   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (snake_valid !== 1'b0 || snake_first !== 1'b0 || snake_last !== 1'b0 ||
          snake_x !== 5'd0 || snake_y !== 4'd0 || move_ready !== 1'b0 ||
          snake_head_x !== 5'd4 || snake_head_y !== 4'd8 || full !== 1'b0 || self_hit !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got v=%b f=%b l=%b x=%0d y=%0d rdy=%b hx=%0d hy=%0d full=%b hit=%b, want 0 0 0 0 0 0 4 8 0 0",
                  snake_valid, snake_first, snake_last, snake_x, snake_y, move_ready,
                  snake_head_x, snake_head_y, full, self_hit);
      end
      rst        = 1'b0;
      move_valid = 1'b0;
      grow       = 1'b0;
      model_q.delete();
      model_q.push_back({5'd4, 4'd8});
      model_full = 1'b0;
      hit_sticky = 1'b0;
   endtask

   task automatic do_move(input logic [4:0] x, input logic [3:0] y, input logic g);
      int n;
      @(negedge clk);
      move_x = x; move_y = y; grow = g; move_valid = 1'b1;
      n = 0;
      while (!move_ready && n < 4 * TB_MAX) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!move_ready) begin
         bad++;
         $display("FAIL move_accept_timeout: move_ready=%b after %0d cycles, want 1", move_ready, n);
      end
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      grow       = 1'b0;
      hit_sticky = hit_sticky | snap_hit();
      if (g && model_q.size() == TB_MAX) model_full = 1'b1;
      model_q.push_front({x, y});
      if (!g || model_q.size() > TB_MAX) void'(model_q.pop_back());
      @(negedge clk);
      total++;
      if (snake_head_x !== x || snake_head_y !== y || full !== model_full) begin
         bad++;
         $display("FAIL head_after_move: got %0d/%0d full=%b, want %0d/%0d full=%b",
                  snake_head_x, snake_head_y, full, x, y, model_full);
      end
   endtask

   task automatic check_pass(input string name);
      int  n;
      bit  exp_hit;
      n = 0;
      @(negedge clk);
      while (!(snake_valid && snake_first) && n < 2 * TB_MAX + 4) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!(snake_valid && snake_first)) begin
         bad++;
         $display("FAIL %s_pass_start: no snake_first within %0d cycles", name, n);
         return;
      end
      exp_hit = COLL & hit_sticky;
      total++;
      if (self_hit !== exp_hit || snake_head_x !== model_q[0][8:4] || snake_head_y !== model_q[0][3:0]) begin
         bad++;
         $display("FAIL %s_pre_pass: got hit=%b head=%0d/%0d, want hit=%b head=%0d/%0d", name,
                  self_hit, snake_head_x, snake_head_y, exp_hit, model_q[0][8:4], model_q[0][3:0]);
      end
      for (int k = 0; k < model_q.size(); k++) begin
         total++;
         if ({snake_x, snake_y} !== model_q[k] || snake_valid !== 1'b1 ||
             snake_first !== (k == 0) || snake_last !== (k == model_q.size() - 1)) begin
            bad++;
            $display("FAIL %s_seg%0d: got (%0d,%0d) v=%b f=%b l=%b, want (%0d,%0d) v=1 f=%b l=%b",
                     name, k, snake_x, snake_y, snake_valid, snake_first, snake_last,
                     model_q[k][8:4], model_q[k][3:0], (k == 0), (k == model_q.size() - 1));
         end
         @(negedge clk);
      end
      hit_sticky = hit_sticky | snap_hit();
      exp_hit = COLL & hit_sticky;
      total++;
      if (self_hit !== exp_hit || snake_first !== 1'b1 || snake_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s_post_pass: got hit=%b next_first=%b v=%b, want hit=%b next_first=1 v=1",
                  name, self_hit, snake_first, snake_valid, exp_hit);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      apply_reset();
      #1;
      total++;
      if (move_ready !== 1'b1 || snake_valid !== 1'b0) begin
         bad++;
         $display("FAIL first_fetch_cycle: got rdy=%b v=%b, want rdy=1 v=0", move_ready, snake_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (snake_valid !== 1'b1 || snake_first !== 1'b1 || snake_last !== 1'b1 ||
             snake_x !== 5'd4 || snake_y !== 4'd8 || snake_head_x !== 5'd4 || snake_head_y !== 4'd8) begin
            bad++;
            $display("FAIL reset_stream%0d: got v=%b f=%b l=%b (%0d,%0d) head %0d/%0d, want 1 1 1 (4,8) head 4/8",
                     i, snake_valid, snake_first, snake_last, snake_x, snake_y, snake_head_x, snake_head_y);
         end
      end
   endtask

   task automatic test_grow();
      int last_i, cnt;
      do_move(5'd5, 4'd8, 1'b1);
      do_move(5'd6, 4'd8, 1'b1);
      check_pass("grow");
      last_i = -1;
      cnt    = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (move_ready) begin
            if (last_i >= 0) begin
               total++;
               if (i - last_i != model_q.size()) begin
                  bad++;
                  $display("FAIL ready_gap: got %0d cycles, want %0d", i - last_i, model_q.size());
               end
            end
            last_i = i;
            cnt++;
         end
      end
      total++;
      if (cnt != 12 / model_q.size()) begin
         bad++;
         $display("FAIL ready_count: got %0d, want %0d", cnt, 12 / model_q.size());
      end
   endtask

   task automatic test_plain_move();
      do_move(5'd7, 4'd8, 1'b0);
      check_pass("plain");
   endtask

   task automatic test_capacity();
      @(negedge clk);
      apply_reset();
      for (int i = 0; i <= TB_MAX; i++) do_move(5'(i + 1), 4'd3, 1'b1);
      check_pass("capacity");
      total++;
      if (full !== 1'b1 || model_q.size() != TB_MAX) begin
         bad++;
         $display("FAIL capacity_full: got full=%b len=%0d, want full=1 len=%0d", full, model_q.size(), TB_MAX);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      apply_reset();
      do_move(5'd5, 4'd5, 1'b1);
      do_move(5'd6, 4'd5, 1'b1);
      do_move(5'd6, 4'd6, 1'b1);
      do_move(5'd5, 4'd6, 1'b1);
      check_pass("coll_body");
      do_move(5'd5, 4'd5, 1'b0);
      check_pass("coll_hit");
      check_pass("coll_sticky");
   endtask

   task automatic test_reset_midpass();
      int n;
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 4; i++) do_move(5'(10 + i), 4'd2, 1'b1);
      check_pass("mid_setup");
      n = 0;
      while (!(snake_valid && snake_first) && n < 2 * TB_MAX) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      move_x = 5'd20; move_y = 4'd15; grow = 1'b1; move_valid = 1'b1;
      apply_reset();
      check_pass("mid_after");
   endtask

   task automatic test_random();
      logic [4:0] x;
      logic [3:0] y;
      logic       g;
      int         pick;
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            pick = $urandom_range(0, model_q.size() - 1);
            x = model_q[pick][8:4];
            y = model_q[pick][3:0];
         end else begin
            x = 5'($urandom_range(1, 20));
            y = 4'($urandom_range(1, 15));
         end
         g = 1'($urandom_range(0, 1));
         do_move(x, y, g);
         check_pass("random");
      end
   endtask

   initial begin
      rst        = 1'b1;
      move_valid = 1'b0;
      move_x     = '0;
      move_y     = '0;
      grow       = 1'b0;
      test_reset();
      test_grow();
      test_plain_move();
      test_capacity();
      test_collision();
      test_reset_midpass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
